// File: rtl/corner_point_collector_pkg.sv
// Shared helpers for the corner point collector: coordinate widths,
// record layout {x, y, score} and parameter legality checks.
package corner_point_collector_pkg;

  // Width of a coordinate counter able to index n positions (at least 1 bit).
  function automatic int coord_w(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

  // Total record width; records are packed as {x, y, score}, score in the LSBs.
  function automatic int rec_w(input int cw, input int rw, input int dw);
    return cw + rw + dw;
  endfunction

  // Bit position of the y field inside a record.
  function automatic int rec_y_lsb(input int dw);
    return dw;
  endfunction

  // Bit position of the x field inside a record.
  function automatic int rec_x_lsb(input int rw, input int dw);
    return rw + dw;
  endfunction

  // Border must exclude at least the last column (it is never evaluated),
  // and the FIFO depth must be a non-zero power of two.
  function automatic bit params_legal(input int brd, input int depth);
    return (brd >= 32'sd1) && (depth >= 32'sd1) && ((depth & (depth - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/corner_fifo.sv
// Synchronous FIFO with registered full/empty flags and a registered head
// record. A push into an empty FIFO shows up at the head on the next cycle.
module corner_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             pixClk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop_ready,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW   = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;
  localparam int CNTW = $clog2(DEPTH + 32'sd1);
  localparam logic [AW-1:0]   PTR_LAST = AW'(DEPTH - 32'sd1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    w_wr_nxt;
  logic [AW-1:0]    w_rd_nxt;
  logic [CNTW-1:0]  r_cnt;
  logic [CNTW-1:0]  w_cnt_nxt;
  logic [CNTW-1:0]  w_remain;
  logic             r_full;
  logic             r_empty;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_pop;
  logic             w_wr;

  // Pointer advance with explicit wrap so any depth stays in range.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == PTR_LAST) begin
      return {AW{1'b0}};
    end else begin
      return p + 1'b1;
    end
  endfunction

  // Handshake, pointer and occupancy next-state; a full FIFO still takes a
  // push when the head leaves in the same cycle.
  always_comb begin
    w_pop     = (!r_empty) && i_pop_ready;
    w_wr      = i_push && ((!r_full) || w_pop);
    w_rd_nxt  = r_rd;
    w_wr_nxt  = r_wr;
    w_remain  = r_cnt;
    w_cnt_nxt = r_cnt;
    if (w_pop) begin
      w_rd_nxt = ptr_inc(r_rd);
      w_remain = r_cnt - 1'b1;
    end else begin
      w_rd_nxt = r_rd;
      w_remain = r_cnt;
    end
    if (w_wr) begin
      w_wr_nxt = ptr_inc(r_wr);
    end else begin
      w_wr_nxt = r_wr;
    end
    case ({w_wr, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Next head value: hold when going empty, take the incoming record when it
  // becomes the only entry, otherwise read the entry behind the old head.
  always_comb begin
    w_data_nxt = r_data;
    if (w_cnt_nxt == {CNTW{1'b0}}) begin
      w_data_nxt = r_data;
    end else if (w_remain == {CNTW{1'b0}}) begin
      w_data_nxt = i_push_data;
    end else begin
      w_data_nxt = r_mem[w_rd_nxt];
    end
  end

  // Control state and registered head/flags.
  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) begin
      r_wr    <= {AW{1'b0}};
      r_rd    <= {AW{1'b0}};
      r_cnt   <= {CNTW{1'b0}};
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_data  <= {WIDTH{1'b0}};
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_FULL);
      r_empty <= (w_cnt_nxt == {CNTW{1'b0}});
      r_data  <= w_data_nxt;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge pixClk) begin
    if (w_wr) begin
      r_mem[r_wr] <= i_push_data;
    end
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_data  = r_data;

endmodule

// File: rtl/corner_point_collector.sv
// Turns a raster-order corner score stream into sparse (x, y, score) records:
// threshold, 1x3 horizontal non-maximum suppression, border exclusion, then
// a FIFO drained over valid/ready.
module corner_point_collector
  import corner_point_collector_pkg::*;
#(
  parameter int dataW     = 8,
  parameter int imageW    = 200,
  parameter int imageH    = 200,
  parameter int border    = 2,
  parameter int fifoDepth = 16,
  parameter int cntW      = 16,
  localparam int CW = coord_w(imageW),
  localparam int RW = coord_w(imageH)
) (
  input  logic             pixClk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [dataW-1:0] in_score,
  input  logic [dataW-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_x,
  output logic [RW-1:0]    out_y,
  output logic [dataW-1:0] out_score,
  output logic             frame_done,
  output logic [cntW-1:0]  drop_cnt
);

  localparam int RECW  = rec_w(CW, RW, dataW);
  localparam int Y_LSB = rec_y_lsb(dataW);
  localparam int X_LSB = rec_x_lsb(RW, dataW);

  localparam logic [CW-1:0] X_LAST = CW'(imageW - 32'sd1);
  localparam logic [RW-1:0] Y_LAST = RW'(imageH - 32'sd1);
  localparam logic [CW-1:0] X_LO   = CW'(border);
  localparam logic [CW-1:0] X_HI   = CW'(imageW - 32'sd1 - border);
  localparam logic [RW-1:0] Y_LO   = RW'(border);
  localparam logic [RW-1:0] Y_HI   = RW'(imageH - 32'sd1 - border);

  if (!params_legal(border, fifoDepth)) begin : g_param_check
    $error("corner_point_collector: border must be >= 1 and fifoDepth a power of two");
  end

  logic [CW-1:0]    r_x;
  logic [RW-1:0]    r_y;
  logic [CW-1:0]    w_cur_x;
  logic [RW-1:0]    w_cur_y;
  logic [CW-1:0]    w_nxt_x;
  logic [RW-1:0]    w_nxt_y;
  logic [CW-1:0]    w_cx;
  logic [dataW-1:0] r_mid;
  logic [dataW-1:0] r_left;
  logic             w_eval;
  logic             w_pass;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [RECW-1:0]  w_push_rec;
  logic [RECW-1:0]  w_head_rec;
  logic             r_frame_done;
  logic [cntW-1:0]  r_drop_cnt;

  // Position of the sample on the input this cycle; in_sof pins it to (0,0).
  always_comb begin
    w_cur_x = r_x;
    w_cur_y = r_y;
    if (in_sof) begin
      w_cur_x = {CW{1'b0}};
      w_cur_y = {RW{1'b0}};
    end else begin
      w_cur_x = r_x;
      w_cur_y = r_y;
    end
  end

  // Raster advance from the current position, wrapping at row and frame end.
  always_comb begin
    w_nxt_x = w_cur_x;
    w_nxt_y = w_cur_y;
    if (w_cur_x == X_LAST) begin
      w_nxt_x = {CW{1'b0}};
      if (w_cur_y == Y_LAST) begin
        w_nxt_y = {RW{1'b0}};
      end else begin
        w_nxt_y = w_cur_y + 1'b1;
      end
    end else begin
      w_nxt_x = w_cur_x + 1'b1;
      w_nxt_y = w_cur_y;
    end
  end

  // Candidate at column x-1 using the incoming score as its right neighbour;
  // ties with the right neighbour go to the leftmost pixel.
  always_comb begin
    w_eval = in_valid && (w_cur_x != {CW{1'b0}});
    w_cx   = w_cur_x - 1'b1;
    w_pass = 1'b0;
    if ((r_mid > thresh) && (r_mid > r_left) && (r_mid >= in_score) &&
        (w_cx >= X_LO) && (w_cx <= X_HI) &&
        (w_cur_y >= Y_LO) && (w_cur_y <= Y_HI)) begin
      w_pass = 1'b1;
    end else begin
      w_pass = 1'b0;
    end
    w_push     = w_eval && w_pass;
    w_push_rec = {w_cx, w_cur_y, r_mid};
  end

  // A push is lost only when the FIFO is full and its head is not leaving.
  always_comb begin
    w_pop  = out_valid && out_ready;
    w_drop = w_push && w_fifo_full && (!w_pop);
  end

  // Raster position counters, advanced on every accepted sample.
  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) begin
      r_x <= {CW{1'b0}};
      r_y <= {RW{1'b0}};
    end else if (in_valid) begin
      r_x <= w_nxt_x;
      r_y <= w_nxt_y;
    end
  end

  // Two-tap horizontal window; restarts at the first column of each row.
  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) begin
      r_mid  <= {dataW{1'b0}};
      r_left <= {dataW{1'b0}};
    end else if (in_valid) begin
      if (w_cur_x == {CW{1'b0}}) begin
        r_left <= {dataW{1'b0}};
      end else begin
        r_left <= r_mid;
      end
      r_mid <= in_score;
    end
  end

  // One-cycle pulse after the last pixel of a frame is accepted.
  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= in_valid && (w_cur_x == X_LAST) && (w_cur_y == Y_LAST);
    end
  end

  // Saturating count of records lost to a full FIFO; only rst clears it.
  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= {cntW{1'b0}};
    end else if (w_drop && (r_drop_cnt != {cntW{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  corner_fifo #(
    .DEPTH (fifoDepth),
    .WIDTH (RECW)
  ) u_fifo (
    .pixClk      (pixClk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_rec),
    .i_pop_ready (out_ready),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_data      (w_head_rec)
  );

  assign out_valid  = ~w_fifo_empty;
  assign out_x      = w_head_rec[X_LSB +: CW];
  assign out_y      = w_head_rec[Y_LSB +: RW];
  assign out_score  = w_head_rec[dataW-1:0];
  assign frame_done = r_frame_done;
  assign drop_cnt   = r_drop_cnt;

endmodule
